// File: rtl/counter_pkg.sv
// Shared counter types: overflow modes and run/done state, reused by all counter variants.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'd0,
        CNT_SAT     = 2'd1,
        CNT_ONESHOT = 2'd2
    } cnt_mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/modulo_counter.sv
// Up/down counter over 0..modulus with wrap, saturate and one-shot overflow modes.
// Parallel load and combinational carry-out allow enable-to-carry cascading.
module modulo_counter
    import counter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         up,
    input  logic [N-1:0] modulus,
    input  logic [1:0]   mode,
    output logic [N-1:0] q,
    output logic         cout,
    output logic         done
);

    cnt_state_t   state, state_nxt;
    logic [N-1:0] q_nxt;
    logic         done_nxt;
    logic         term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            state <= RUN;
            done  <= 1'b0;
        end else begin
            q     <= q_nxt;
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        term      = up ? (q >= modulus) : (q == '0);
        q_nxt     = q;
        state_nxt = state;
        done_nxt  = done;
        if (clear) begin
            q_nxt     = '0;
            state_nxt = RUN;
            done_nxt  = 1'b0;
        end else if (load) begin
            q_nxt     = (d > modulus) ? modulus : d;
            state_nxt = RUN;
            done_nxt  = 1'b0;
        end else if (enable && state == RUN) begin
            if (!term) begin
                if (up)
                    q_nxt = q + 1'b1;
                else if (q > modulus)
                    q_nxt = modulus;  // modulus lowered below q while counting down
                else
                    q_nxt = q - 1'b1;
            end else begin
                // reserved mode encoding falls through to wrap
                case (cnt_mode_t'(mode))
                    CNT_SAT: q_nxt = q;
                    CNT_ONESHOT: begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                    default: q_nxt = up ? '0 : modulus;
                endcase
            end
        end
    end

    // Gated by rst_n so the carry stays quiet while reset is asserted.
    always_comb begin
        cout = rst_n & enable & (state == RUN) & term;
    end

endmodule
